// File: rtl/gf_mult_serial_pkg.sv
// Shared types, constants and helpers for the digit-serial GF(2^W) multiplier.
package gf_mult_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [127:0] GCM_POLY = 128'h87;
   localparam int REV_MAX = 512;

   // Reverses the low w bits of x; bits at or above w come back as zero.
   function automatic logic [REV_MAX-1:0] bit_reverse(input logic [REV_MAX-1:0] x, input int w);
      logic [REV_MAX-1:0] r;
      logic [REV_MAX-1:0] xs;
      r  = '0;
      xs = x;
      for (int i = 0; i < REV_MAX; i++) begin
         if (i < w) begin
            r  = {r[REV_MAX-2:0], xs[0]};
            xs = xs >> 1;
         end
      end
      return r;
   endfunction
endpackage

// File: rtl/gf_mult_serial_if.sv
// Operand/result handshake bundle for gf_mult_serial.
interface gf_mult_serial_if #(parameter int W = 128);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] z;

   modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, z);
   modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, z);
endinterface

// File: rtl/gf_mult_serial_digit_step.sv
// One clock of the MSB-first multiply: DIGIT unrolled shift-reduce-add steps.
module gf_digit_step
   import gf_mult_pkg::*;
#(
   parameter int           W     = 128,
   parameter int           DIGIT = 4,
   parameter logic [W-1:0] POLY  = W'(GCM_POLY)
) (
   input  logic [W-1:0]     acc,
   input  logic [W-1:0]     a,
   input  logic [DIGIT-1:0] b,
   output logic [W-1:0]     acc_next
);
   logic [W-1:0]     t;
   logic [DIGIT-1:0] bs;

   always_comb begin
      t  = acc;
      bs = b;
      for (int i = 0; i < DIGIT; i++) begin
         t = {t[W-2:0], 1'b0} ^ (t[W-1] ? POLY : '0);
         if (bs[DIGIT-1]) t = t ^ a;
         bs = bs << 1;
      end
      acc_next = t;
   end
endmodule

// File: rtl/gf_mult_serial.sv
// Digit-serial GF(2^W) multiplier with in-loop reduction; optional GCM bit reflection.
module gf_mult_serial
   import gf_mult_pkg::*;
#(
   parameter int           W       = 128,
   parameter int           DIGIT   = 4,
   parameter logic [W-1:0] POLY    = W'(GCM_POLY),
   parameter int           REFLECT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   gf_mult_serial_if.slave bus
);
   localparam int NSTEP = W / DIGIT;
   localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

   state_t             state, state_nxt;
   logic [W-1:0]       a_q, b_q, acc, acc_nxt, z_q, a_core, b_core;
   logic [CW-1:0]      cnt;
   logic [REV_MAX-1:0] a_ext, b_ext, z_ext;
   logic               accept;

   // The core works in plain polynomial order; reflection happens only at the edges.
   always_comb begin
      a_ext = '0;
      b_ext = '0;
      z_ext = '0;
      a_ext[W-1:0] = bus.a;
      b_ext[W-1:0] = bus.b;
      z_ext[W-1:0] = z_q;
      a_core = (REFLECT != 0) ? W'(bit_reverse(a_ext, W)) : bus.a;
      b_core = (REFLECT != 0) ? W'(bit_reverse(b_ext, W)) : bus.b;
      bus.z  = (REFLECT != 0) ? W'(bit_reverse(z_ext, W)) : z_q;
   end

   gf_digit_step #(.W(W), .DIGIT(DIGIT), .POLY(POLY)) u_step (
      .acc      (acc),
      .a        (a_q),
      .b        (b_q[W-1 -: DIGIT]),
      .acc_next (acc_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.in_valid) state_nxt = BUSY;
         BUSY: if (cnt == LAST) state_nxt = DONE;
         DONE: if (bus.out_ready) state_nxt = bus.in_valid ? BUSY : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
      bus.out_valid = (state == DONE);
      accept        = bus.in_valid && bus.in_ready;
   end

   // B is shifted left each cycle so its top DIGIT bits are always the next digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         acc <= '0;
         cnt <= '0;
         z_q <= '0;
      end else if (accept) begin
         a_q <= a_core;
         b_q <= b_core;
         acc <= '0;
         cnt <= '0;
      end else if (state == BUSY) begin
         acc <= acc_nxt;
         b_q <= b_q << DIGIT;
         cnt <= cnt + 1'b1;
         if (cnt == LAST) z_q <= acc_nxt;
      end
   end
endmodule

// File: doc/gf_mult_serial.md
Name: gf_mult_serial

Overview:
- Parametrised, digit-serial GF(2^W) multiplier with built-in modular reduction and valid/ready handshakes.
- Next-generation replacement for the combinational 128-bit Karatsuba multiplier plus separate reduction stage.
- Processes DIGIT bits of operand B per clock and emits a fully reduced W-bit field product.
- Sits in the GHASH/GCM datapath; REFLECT selects GCM bit ordering or plain polynomial ordering.

Parameters:
- W, 128: field width in bits; the reduction polynomial has degree W.
- DIGIT, 4: bits of B consumed per cycle. Legal values are 1 to W, and W % DIGIT must be 0.
- POLY, 128'h87: low W bits of the reduction polynomial; x^W is implicit. The default gives x^128+x^7+x^2+x+1.
- REFLECT, 1: 1 means GCM bit-reflected operands and result (bit 0 of a word = coefficient of x^127); 0 means bit i = coefficient of x^i.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst_n  in  1  Reset. Asynchronous, active-low.
- in_valid  in  1  Operand pair a/b is valid.
- in_ready  out  1  Block can accept an operand pair this cycle.
- a  in  W  Multiplicand.
- b  in  W  Multiplier; consumed DIGIT bits per cycle.
- out_valid  out  1  Result is valid.
- out_ready  in  1  Downstream accepts the result.
- z  out  W  Reduced product a·b mod P, in the same bit order as the inputs.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; out_valid=0; z=0; the internal accumulator and counter clear.
  - Any operation in flight is discarded. After release, the first accept is possible on the first clock edge.
- Input mapping: if REFLECT=1, a and b are bit-reversed on capture and z is bit-reversed on output. The core always works in plain polynomial order.
- States:
  - IDLE: in_ready=1. On in_valid, latch A and B, set ACC=0 and CNT=0, go to BUSY.
  - BUSY: in_ready=0. Each cycle, take the next DIGIT most-significant bits of B (MSB first). For each bit, in order:
    - ACC = (ACC<<1) ^ (ACC[W-1] ? POLY : 0)
    - then ACC ^= (bit ? A : 0)
    - CNT increments each cycle. When CNT = W/DIGIT-1, go to DONE and register z = ACC_next.
  - DONE: out_valid=1 and z is held stable until the handshake.
    - out_ready=1 with in_valid=0: go to IDLE and drop out_valid on the next edge.
    - out_ready=1 with in_valid=1: in_ready=1; the new pair is captured in the same cycle and the state goes straight to BUSY (back-to-back, no IDLE bubble).
    - out_ready=0: stay in DONE; in_ready=0.
- Latency: W/DIGIT cycles from the accept edge to out_valid high. Defaults give 32 cycles.
- Throughput: one result per W/DIGIT+1 cycles under continuous valid/ready.
- Handshake rules:
  - in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and out_ready only, never from in_valid.
  - Once out_valid is asserted, z and out_valid must not change until out_ready=1.
  - in_valid is ignored in BUSY.
- Arithmetic: carry-less (XOR) only. ACC is always fully reduced and below degree W. No wide product is ever materialised.
- Edge cases:
  - a=0 or b=0 gives z=0 at full latency; there is no early exit.
  - DIGIT=W is a single-cycle BUSY.
- CNT width: $clog2(W/DIGIT), minimum 1.

Decomposition:
- Package gf_mult_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - GCM_POLY constant 128'h87;
  - bit_reverse function, parametrised by width.
- Sub-module gf_digit_step (combinational): inputs acc, a, and a DIGIT-bit b slice; output is the next acc after DIGIT unrolled shift-reduce-add steps. It is parametrised by W, DIGIT and POLY.
- The top level holds the FSM, counter, operand registers and the reflect muxes.

Test Plan:
1. REFLECT=1, a=66e94bd4ef8a2c3b884cfa59ca342b2e, b=0388dace60b6a392f328c2b971b2fe78 -> z=5e2ec746917062882c85b0685353deb7, with out_valid exactly 32 cycles after accept.
2. REFLECT=0:
   - a=8000...0 (x^127), b=2 (x) -> z=00..0087;
   - a=1, b=X -> z=X;
   - a=0, b=FFFF...F -> z=0.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid. z and out_valid stay stable and in_ready=0; then out_ready=1 together with in_valid=1 -> the new pair is accepted in that same cycle.
4. Reset mid-operation: drop rst_n asynchronously (off-edge) 5 cycles into BUSY -> out_valid=0 and z=0 immediately. After release, a fresh op from test 1 gives the correct result.
5. Sweep DIGIT in {1,4,8,128} with 200 random pairs against a bit-serial reference model -> all match, with latency of 128, 32, 16 and 1 cycles respectively.
6. Back-to-back stream of 50 ops with in_valid and out_ready held at 1 -> one result every W/DIGIT+1 cycles, results in order, no drops or duplicates.
